// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration-time helpers for the reset sequencer / run watchdog.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_TMO  = 2'd3
   } state_e;

   // Edge count (since reset release) at which channel k leaves reset.
   function automatic int unsigned rel_point(input int unsigned hold,
                                             input int unsigned stagger,
                                             input int unsigned k);
      return hold + k * stagger;
   endfunction

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/sat_cnt.sv
// Up-counter with enable, synchronous clear and async reset; sticks at all-ones.
module sat_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   input  logic         i_clr,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        r_cnt <= '0;
      else if (i_clr)                 r_cnt <= '0;
      else if (i_en && (r_cnt != '1)) r_cnt <= r_cnt + W'(1);
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/rst_seq_watchdog.sv
// Staggered multi-channel reset release followed by a run phase with cycle
// counting, halt detection and an optional watchdog timeout.
module rst_seq_watchdog
   import rst_seq_pkg::*;
#(
   parameter int unsigned     NUM_CH      = 2,
   parameter int unsigned     HOLD_CYCLES = 25,
   parameter int unsigned     STAGGER     = 4,
   parameter int unsigned     CNT_W       = 40,
   parameter longint unsigned TIMEOUT     = 64'd1000000,
   parameter bit              TIMEOUT_RST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              soft_rst,
   input  logic              halt_req,
   input  logic              pause,
   output logic [NUM_CH-1:0] ch_rst_o,
   output logic              run,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic              done,
   output logic              timeout,
   output logic [1:0]        state_o
);

   localparam int unsigned      LAST_REL = rel_point(HOLD_CYCLES, STAGGER, NUM_CH - 1);
   localparam int unsigned      REL_W    = clog2(LAST_REL + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 64'd1);

   if (NUM_CH == 0 || HOLD_CYCLES == 0) begin : g_bad_geometry
      $error("rst_seq_watchdog: NUM_CH and HOLD_CYCLES must be at least 1");
   end
   if (CNT_W < 64 && TIMEOUT > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_timeout
      $error("rst_seq_watchdog: TIMEOUT does not fit in CNT_W bits");
   end

   state_e              r_state;
   logic [NUM_CH-1:0]   r_ch_rst;
   logic                r_run;
   logic                r_done;
   logic                r_timeout;

   logic [REL_W-1:0]    w_rel_cnt;
   logic [CNT_W-1:0]    w_cycle_cnt;
   logic [31:0]         w_m_next;
   logic                w_rel_en;
   logic                w_cyc_en;
   logic                w_tmo_hit;

   // w_m_next is M after the coming edge; the halting edge is never counted.
   assign w_m_next  = 32'(w_rel_cnt) + 32'd1;
   assign w_rel_en  = (r_state == ST_HOLD);
   assign w_cyc_en  = (r_state == ST_RUN) && !pause && !halt_req;
   assign w_tmo_hit = (TIMEOUT != 64'd0) && (w_cycle_cnt == TMO_LAST) && !pause;

   sat_cnt #(.W(REL_W)) u_rel_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_rel_en),
      .i_clr (soft_rst),
      .o_cnt (w_rel_cnt)
   );

   sat_cnt #(.W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_cyc_en),
      .i_clr (soft_rst),
      .o_cnt (w_cycle_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_HOLD;
         r_ch_rst  <= '1;
         r_run     <= 1'b0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
      end else if (soft_rst) begin
         r_state   <= ST_HOLD;
         r_ch_rst  <= '1;
         r_run     <= 1'b0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         case (r_state)
            ST_HOLD: begin
               for (int unsigned k = 0; k < NUM_CH; k++)
                  r_ch_rst[k] <= (w_m_next < rel_point(HOLD_CYCLES, STAGGER, k));
               if (w_m_next >= LAST_REL) begin
                  r_state <= ST_RUN;
                  r_run   <= 1'b1;
               end
            end
            ST_RUN: begin
               // Halt outranks a simultaneous watchdog hit.
               if (halt_req) begin
                  r_state <= ST_DONE;
                  r_run   <= 1'b0;
                  r_done  <= 1'b1;
               end else if (w_tmo_hit) begin
                  r_state   <= ST_TMO;
                  r_run     <= 1'b0;
                  r_timeout <= 1'b1;
                  if (TIMEOUT_RST) r_ch_rst <= '1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign ch_rst_o  = r_ch_rst;
   assign run       = r_run;
   assign cycle_cnt = w_cycle_cnt;
   assign done      = r_done;
   assign timeout   = r_timeout;
   assign state_o   = r_state;

endmodule

// File: tb/tb_rst_seq_watchdog.sv
// Self-checking bench: four differently parametrised instances share stimulus
// and are compared against a behavioural model of the release/run rules.
module tb_rst_seq_watchdog;

   localparam int NI = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic soft_rst = 1'b0;
   logic halt_req = 1'b0;
   logic pause = 1'b0;

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // Instance 0: defaults; 1: TIMEOUT=50 re-assert; 2: TIMEOUT=50 keep released; 3: 4ch, no stagger, 8-bit, no watchdog
   logic [1:0]  ch_0, ch_1, ch_2;
   logic [3:0]  ch_3;
   logic        run_0, run_1, run_2, run_3;
   logic [39:0] cnt_0, cnt_1, cnt_2;
   logic [7:0]  cnt_3;
   logic        done_0, done_1, done_2, done_3;
   logic        tmo_0, tmo_1, tmo_2, tmo_3;
   logic [1:0]  st_0, st_1, st_2, st_3;

   rst_seq_watchdog u_def (
      .clk(clk), .rst(rst), .soft_rst(soft_rst), .halt_req(halt_req), .pause(pause),
      .ch_rst_o(ch_0), .run(run_0), .cycle_cnt(cnt_0), .done(done_0), .timeout(tmo_0), .state_o(st_0)
   );

   rst_seq_watchdog #(.TIMEOUT(64'd50), .TIMEOUT_RST(1'b1)) u_t50r (
      .clk(clk), .rst(rst), .soft_rst(soft_rst), .halt_req(halt_req), .pause(pause),
      .ch_rst_o(ch_1), .run(run_1), .cycle_cnt(cnt_1), .done(done_1), .timeout(tmo_1), .state_o(st_1)
   );

   rst_seq_watchdog #(.TIMEOUT(64'd50), .TIMEOUT_RST(1'b0)) u_t50n (
      .clk(clk), .rst(rst), .soft_rst(soft_rst), .halt_req(halt_req), .pause(pause),
      .ch_rst_o(ch_2), .run(run_2), .cycle_cnt(cnt_2), .done(done_2), .timeout(tmo_2), .state_o(st_2)
   );

   rst_seq_watchdog #(.NUM_CH(4), .STAGGER(0), .CNT_W(8), .TIMEOUT(64'd0)) u_w4 (
      .clk(clk), .rst(rst), .soft_rst(soft_rst), .halt_req(halt_req), .pause(pause),
      .ch_rst_o(ch_3), .run(run_3), .cycle_cnt(cnt_3), .done(done_3), .timeout(tmo_3), .state_o(st_3)
   );

   logic [3:0]  o_ch   [NI];
   logic        o_run  [NI];
   logic [63:0] o_cnt  [NI];
   logic        o_done [NI];
   logic        o_tmo  [NI];
   logic [1:0]  o_st   [NI];

   assign o_ch[0] = {2'b00, ch_0};  assign o_ch[1] = {2'b00, ch_1};
   assign o_ch[2] = {2'b00, ch_2};  assign o_ch[3] = ch_3;
   assign o_run[0] = run_0;  assign o_run[1] = run_1;  assign o_run[2] = run_2;  assign o_run[3] = run_3;
   assign o_cnt[0] = {24'd0, cnt_0};  assign o_cnt[1] = {24'd0, cnt_1};
   assign o_cnt[2] = {24'd0, cnt_2};  assign o_cnt[3] = {56'd0, cnt_3};
   assign o_done[0] = done_0;  assign o_done[1] = done_1;  assign o_done[2] = done_2;  assign o_done[3] = done_3;
   assign o_tmo[0] = tmo_0;  assign o_tmo[1] = tmo_1;  assign o_tmo[2] = tmo_2;  assign o_tmo[3] = tmo_3;
   assign o_st[0] = st_0;  assign o_st[1] = st_1;  assign o_st[2] = st_2;  assign o_st[3] = st_3;

   // ---------------- instance parameters as seen by the model ----------------
   function automatic int p_nch(int i);   return (i == 3) ? 4 : 2;  endfunction
   function automatic int p_hold(int i);  return 25;                endfunction
   function automatic int p_stag(int i);  return (i == 3) ? 0 : 4;  endfunction
   function automatic int p_cw(int i);    return (i == 3) ? 8 : 40; endfunction
   function automatic bit p_trst(int i);  return (i != 2);          endfunction
   function automatic longint unsigned p_to(int i);
      case (i)
         0:       return 64'd1000000;
         1, 2:    return 64'd50;
         default: return 64'd0;
      endcase
   endfunction
   function automatic int last_rel(int i);
      return p_hold(i) + (p_nch(i) - 1) * p_stag(i);
   endfunction
   function automatic longint unsigned cnt_max(int i);
      return (64'd1 << p_cw(i)) - 64'd1;
   endfunction
   function automatic logic [3:0] all_ch(int i);
      return (p_nch(i) == 4) ? 4'hF : 4'h3;
   endfunction

   // ---------------- behavioural model ----------------
   // m: edges since release (capped once all channels are out), cnt: counted run cycles.
   int              m_m    [NI];
   longint unsigned m_cnt  [NI];
   bit              m_done [NI];
   bit              m_tmo  [NI];

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         m_m[i] = 0;  m_cnt[i] = 0;  m_done[i] = 1'b0;  m_tmo[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      if (rst || soft_rst) begin
         model_reset();
      end else begin
         for (int i = 0; i < NI; i++) begin
            if (m_m[i] < last_rel(i)) begin
               m_m[i]++;
            end else if (!m_done[i] && !m_tmo[i]) begin
               if (halt_req) begin
                  m_done[i] = 1'b1;
               end else if (!pause) begin
                  if (p_to(i) != 0 && m_cnt[i] == p_to(i) - 1) begin
                     m_cnt[i] = p_to(i);
                     m_tmo[i] = 1'b1;
                  end else if (m_cnt[i] < cnt_max(i)) begin
                     m_cnt[i]++;
                  end
               end
            end
         end
      end
   endtask

   function automatic logic [3:0] exp_ch(int i);
      logic [3:0] v;
      v = 4'h0;
      for (int k = 0; k < 4; k++)
         if (k < p_nch(i))
            v[k] = (m_tmo[i] && p_trst(i)) ? 1'b1 : (m_m[i] < p_hold(i) + k * p_stag(i));
      return v;
   endfunction

   function automatic logic [1:0] exp_st(int i);
      if (m_done[i])              return 2'd2;
      if (m_tmo[i])               return 2'd3;
      if (m_m[i] >= last_rel(i))  return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [72:0] exp_vec(int i);
      logic er;
      er = (m_m[i] >= last_rel(i)) && !m_done[i] && !m_tmo[i];
      return {exp_ch(i), er, 64'(m_cnt[i]), m_done[i], m_tmo[i], exp_st(i)};
   endfunction

   function automatic logic [72:0] obs_vec(int i);
      return {o_ch[i], o_run[i], o_cnt[i], o_done[i], o_tmo[i], o_st[i]};
   endfunction

   // One rising edge, then settle to the falling edge where outputs are sampled and inputs change.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;  soft_rst = 1'b0;  halt_req = 1'b0;  pause = 1'b0;
      #1 model_reset();
      repeat (5) tick();
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;  soft_rst = 1'b0;  halt_req = 1'b0;  pause = 1'b0;
      #1 model_reset();
      repeat (5) tick();
      for (int i = 0; i < NI; i++) begin
         n_total++;
         if (obs_vec(i) !== {all_ch(i), 1'b0, 64'd0, 1'b0, 1'b0, 2'd0})
            $display("FAIL reset_state inst=%0d got=%h exp=%h", i, obs_vec(i),
                     {all_ch(i), 1'b0, 64'd0, 1'b0, 1'b0, 2'd0});
         else n_pass++;
      end
      rst = 1'b0;
   endtask

   task automatic test_release();
      do_reset();
      for (int e = 1; e <= 31; e++) begin
         tick();
         n_total++;
         if ({o_ch[0][1:0], o_run[0], o_st[0]} !== {(e < 29), (e < 25), (e >= 29), (e >= 29) ? 2'd1 : 2'd0})
            $display("FAIL release_def edge=%0d got ch=%b run=%b st=%0d exp ch=%b%b run=%b",
                     e, o_ch[0][1:0], o_run[0], o_st[0], (e < 29), (e < 25), (e >= 29));
         else n_pass++;
         n_total++;
         if ({o_ch[3], o_run[3]} !== {(e < 25) ? 4'hF : 4'h0, (e >= 25)})
            $display("FAIL release_4ch edge=%0d got ch=%b run=%b exp ch=%b run=%b",
                     e, o_ch[3], o_run[3], (e < 25) ? 4'hF : 4'h0, (e >= 25));
         else n_pass++;
      end
   endtask

   task automatic test_halt();
      logic [72:0] frozen;
      do_reset();
      repeat (29 + 100) tick();
      n_total++;
      if (o_cnt[0] !== 64'd100) $display("FAIL halt_precount got=%0d exp=100", o_cnt[0]);
      else n_pass++;
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      n_total++;
      if ({o_done[0], o_st[0], o_cnt[0], o_run[0], o_ch[0][1:0]} !== {1'b1, 2'd2, 64'd100, 1'b0, 2'b00})
         $display("FAIL halt_done got done=%b st=%0d cnt=%0d run=%b ch=%b exp done=1 st=2 cnt=100 run=0 ch=00",
                  o_done[0], o_st[0], o_cnt[0], o_run[0], o_ch[0][1:0]);
      else n_pass++;
      frozen = {4'h0, 1'b0, 64'd100, 1'b1, 1'b0, 2'd2};
      for (int c = 0; c < 20; c++) begin
         halt_req = 1'($urandom_range(0, 1));
         pause    = 1'($urandom_range(0, 1));
         tick();
         n_total++;
         if (obs_vec(0) !== frozen) $display("FAIL halt_terminal cyc=%0d got=%h exp=%h", c, obs_vec(0), frozen);
         else n_pass++;
      end
      halt_req = 1'b0;  pause = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
      repeat (29 + 49) tick();
      n_total++;
      if ({o_cnt[1], o_st[1], o_tmo[1]} !== {64'd49, 2'd1, 1'b0})
         $display("FAIL tmo_before got cnt=%0d st=%0d tmo=%b exp cnt=49 st=1 tmo=0", o_cnt[1], o_st[1], o_tmo[1]);
      else n_pass++;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_total++;
         if ({o_cnt[1], o_tmo[1], o_st[1], o_ch[1][1:0], o_run[1]} !== {64'd50, 1'b1, 2'd3, 2'b11, 1'b0})
            $display("FAIL tmo_rst cyc=%0d got cnt=%0d tmo=%b st=%0d ch=%b run=%b exp cnt=50 tmo=1 st=3 ch=11 run=0",
                     c, o_cnt[1], o_tmo[1], o_st[1], o_ch[1][1:0], o_run[1]);
         else n_pass++;
         n_total++;
         if ({o_cnt[2], o_tmo[2], o_st[2], o_ch[2][1:0], o_run[2]} !== {64'd50, 1'b1, 2'd3, 2'b00, 1'b0})
            $display("FAIL tmo_norst cyc=%0d got cnt=%0d tmo=%b st=%0d ch=%b run=%b exp cnt=50 tmo=1 st=3 ch=00 run=0",
                     c, o_cnt[2], o_tmo[2], o_st[2], o_ch[2][1:0], o_run[2]);
         else n_pass++;
      end
   endtask

   task automatic test_halt_vs_timeout();
      do_reset();
      repeat (29 + 49) tick();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      n_total++;
      if ({o_st[1], o_done[1], o_tmo[1], o_cnt[1]} !== {2'd2, 1'b1, 1'b0, 64'd49})
         $display("FAIL halt_wins got st=%0d done=%b tmo=%b cnt=%0d exp st=2 done=1 tmo=0 cnt=49",
                  o_st[1], o_done[1], o_tmo[1], o_cnt[1]);
      else n_pass++;

      do_reset();
      repeat (29 + 49) tick();
      pause = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_total++;
         if ({o_cnt[1], o_st[1], o_tmo[1]} !== {64'd49, 2'd1, 1'b0})
            $display("FAIL pause_blocks_tmo cyc=%0d got cnt=%0d st=%0d tmo=%b exp cnt=49 st=1 tmo=0",
                     c, o_cnt[1], o_st[1], o_tmo[1]);
         else n_pass++;
      end
      pause = 1'b0;
      tick();
      n_total++;
      if ({o_cnt[1], o_st[1], o_tmo[1]} !== {64'd50, 2'd3, 1'b1})
         $display("FAIL tmo_after_pause got cnt=%0d st=%0d tmo=%b exp cnt=50 st=3 tmo=1", o_cnt[1], o_st[1], o_tmo[1]);
      else n_pass++;
   endtask

   task automatic test_soft_rst();
      do_reset();
      repeat (10) tick();
      soft_rst = 1'b1;
      tick();
      soft_rst = 1'b0;
      n_total++;
      if ({o_ch[0][1:0], o_st[0], o_run[0]} !== {2'b11, 2'd0, 1'b0})
         $display("FAIL soft_hold got ch=%b st=%0d run=%b exp ch=11 st=0 run=0", o_ch[0][1:0], o_st[0], o_run[0]);
      else n_pass++;
      for (int e = 1; e <= 29; e++) begin
         tick();
         n_total++;
         if ({o_ch[0][1:0], o_run[0]} !== {(e < 29), (e < 25), (e >= 29)})
            $display("FAIL soft_restart edge=%0d got ch=%b run=%b exp ch=%b%b run=%b",
                     e, o_ch[0][1:0], o_run[0], (e < 29), (e < 25), (e >= 29));
         else n_pass++;
      end
      repeat (5) tick();
      soft_rst = 1'b1;
      tick();
      soft_rst = 1'b0;
      n_total++;
      if ({o_ch[0][1:0], o_st[0], o_cnt[0], o_run[0]} !== {2'b11, 2'd0, 64'd0, 1'b0})
         $display("FAIL soft_run got ch=%b st=%0d cnt=%0d run=%b exp ch=11 st=0 cnt=0 run=0",
                  o_ch[0][1:0], o_st[0], o_cnt[0], o_run[0]);
      else n_pass++;

      // Asynchronous rst in the middle of the clock-low phase.
      repeat (29 + 3) tick();
      #2 rst = 1'b1;
      #1 model_reset();
      n_total++;
      if ({o_ch[0][1:0], o_run[0], o_cnt[0], o_st[0]} !== {2'b11, 1'b0, 64'd0, 2'd0})
         $display("FAIL async_rst got ch=%b run=%b cnt=%0d st=%0d exp ch=11 run=0 cnt=0 st=0",
                  o_ch[0][1:0], o_run[0], o_cnt[0], o_st[0]);
      else n_pass++;
      tick();
      rst = 1'b0;
      for (int e = 1; e <= 25; e++) begin
         tick();
         if (e >= 24) begin
            n_total++;
            if (o_ch[0][0] !== (e < 25))
               $display("FAIL async_restart edge=%0d got ch0=%b exp=%b", e, o_ch[0][0], (e < 25));
            else n_pass++;
         end
      end
   endtask

   task automatic test_saturate();
      do_reset();
      repeat (25) tick();
      n_total++;
      if ({o_run[3], o_ch[3]} !== {1'b1, 4'h0})
         $display("FAIL sat_run got run=%b ch=%b exp run=1 ch=0000", o_run[3], o_ch[3]);
      else n_pass++;
      repeat (255) tick();
      n_total++;
      if (o_cnt[3] !== 64'd255) $display("FAIL sat_reach got=%0d exp=255", o_cnt[3]);
      else n_pass++;
      repeat (45) tick();
      n_total++;
      if ({o_cnt[3], o_st[3], o_tmo[3]} !== {64'd255, 2'd1, 1'b0})
         $display("FAIL sat_hold got cnt=%0d st=%0d tmo=%b exp cnt=255 st=1 tmo=0", o_cnt[3], o_st[3], o_tmo[3]);
      else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 1200; c++) begin
         soft_rst = ($urandom_range(0, 149) == 0);
         halt_req = ($urandom_range(0, 69) == 0);
         pause    = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            #1 model_reset();
         end else begin
            rst = 1'b0;
         end
         tick();
         for (int i = 0; i < NI; i++) begin
            n_total++;
            if (obs_vec(i) !== exp_vec(i))
               $display("FAIL random cyc=%0d inst=%0d got=%h exp=%h", c, i, obs_vec(i), exp_vec(i));
            else n_pass++;
         end
      end
      rst = 1'b0;  soft_rst = 1'b0;  halt_req = 1'b0;  pause = 1'b0;
   endtask

   initial begin
      test_reset();
      test_release();
      test_halt();
      test_timeout();
      test_halt_vs_timeout();
      test_soft_rst();
      test_saturate();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rst_seq_watchdog.md
Name: rst_seq_watchdog

Overview:
- Parametrised reset sequencer and run watchdog.
- Generalises the fixed "hold reset N half-periods, then run until a hard timeout" pattern used around riscv_top:
  - multi-channel staggered reset release;
  - cycle counting with pause;
  - halt detection;
  - a configurable timeout.
- Sits between the raw board/bench reset and the DUT reset domains (core, memory/IO).
- Exposes run status to the bench or to LED/UART logic.

Parameters:
- NUM_CH, 2: number of reset channels (>=1).
- HOLD_CYCLES, 25: rising edges for which all channels stay in reset after rst deasserts (>=1).
- STAGGER, 4: extra edges between successive channel releases (0 = all release together).
- CNT_W, 40: width of cycle_cnt.
- TIMEOUT, 1000000: run cycles before timeout; 0 disables the watchdog.
- TIMEOUT_RST, 1: 1 = re-assert all channels on timeout; 0 = leave them released.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- soft_rst  in  1  synchronous request to restart the whole sequence.
- halt_req  in  1  DUT signals program end; sampled only in RUN.
- pause  in  1  freezes cycle_cnt in RUN.
- ch_rst_o  out  NUM_CH  per-channel active-high reset; bit k covers domain k.
- run  out  1  all channels released and state is RUN.
- cycle_cnt  out  CNT_W  cycles counted in RUN.
- done  out  1  sticky; halt seen.
- timeout  out  1  sticky; watchdog fired.
- state_o  out  2  current state encoding (see package).

Behaviour:
- **States:** HOLD=0, RUN=1, DONE=2, TMO=3.
- **Reset (rst=1, asynchronous):**
  - state=HOLD, rel_cnt=0, ch_rst_o=all ones, run=0, cycle_cnt=0, done=0, timeout=0.
  - rst dominates every other input.
- **HOLD:**
  - rel_cnt increments every edge and is ignored once it exceeds the last release point.
  - Let M = number of rising edges with rst=0 since release.
  - ch_rst_o[k] is registered and equals (M < HOLD_CYCLES + k*STAGGER).
  - Transition to RUN on the edge where M = HOLD_CYCLES + (NUM_CH-1)*STAGGER.
  - run rises on that same edge, together with the last channel release.
  - pause and halt_req are ignored in HOLD.
- **RUN:**
  - cycle_cnt increments by 1 each edge while pause=0.
  - cycle_cnt saturates at all-ones, with no wrap.
  - halt_req=1 → next edge: state=DONE, done=1, cycle_cnt frozen (the halting edge is not counted).
  - TIMEOUT≠0 and cycle_cnt = TIMEOUT-1 with pause=0 → next edge: cycle_cnt=TIMEOUT, state=TMO, timeout=1.
  - Simultaneous halt_req and timeout hit on the same edge → DONE wins; timeout stays 0.
  - pause=1 on the would-be timeout edge → no timeout; the count holds.
- **DONE:**
  - Terminal; channels stay released, run=0, outputs hold.
  - Leave only via rst or soft_rst.
- **TMO:**
  - Terminal; run=0.
  - ch_rst_o = all ones if TIMEOUT_RST=1, else held released.
- **soft_rst=1 at an edge (rst=0):**
  - Same register values as rst, but synchronous.
  - The sequence restarts with M counted from the following edge.
  - Honoured in every state, including mid-HOLD.
- **Width rules:**
  - TIMEOUT must fit in CNT_W; elaboration error otherwise.
  - rel_cnt width = clog2(HOLD_CYCLES + (NUM_CH-1)*STAGGER + 1).
- **Latency:** all outputs are registered; no combinational input→output paths.

Decomposition:
- Package rst_seq_pkg holds:
  - state enum (HOLD, RUN, DONE, TMO) with 2-bit encoding;
  - function computing the release point HOLD_CYCLES + k*STAGGER;
  - clog2 helper.
- One sub-module, sat_cnt: parametrised width, enable, sync clear, async reset, saturating at all-ones.
  - Instantiated for cycle_cnt and for rel_cnt.

Test Plan:
1. Defaults, rst high 5 edges then low:
   - ch_rst_o[0] falls after edge 25, ch_rst_o[1] after edge 29;
   - run=1 and state_o=1 after edge 29.
2. RUN, then halt_req pulsed after 100 counted cycles:
   - done=1, state_o=2, cycle_cnt stays 100;
   - later halt_req and pause toggles produce no change.
3. TIMEOUT=50, TIMEOUT_RST=1, no halt:
   - at cycle_cnt=50, timeout=1, state_o=3, ch_rst_o=2'b11.
   - Repeat with TIMEOUT_RST=0: ch_rst_o stays 2'b00.
4. TIMEOUT=50, halt_req asserted when cycle_cnt=49:
   - DONE, done=1, timeout=0, cycle_cnt=49.
   - With pause=1 at cycle_cnt=49: no timeout until pause drops.
5. soft_rst at M=10 in HOLD, and rst asserted mid-clock-low in RUN:
   - ch_rst_o returns to 2'b11 immediately (async) or at the edge (soft);
   - release timing restarts from 0.
6. NUM_CH=4, STAGGER=0, CNT_W=8, TIMEOUT=0:
   - all channels release on edge 25;
   - cycle_cnt saturates at 255 and never times out.
